// File: rtl/bp_event_counter_bank.sv
// bp_event_counter_bank: per-event performance counters with a snapshot shadow bank,
// windowed auto-sampling, sticky overflow flags and a one-cycle-latency indexed read port.
module bp_event_counter_bank #(
    parameter int num_events_p  = 32,
    parameter int width_p       = 32,
    parameter int saturate_p    = 1,
    parameter int stop_on_ovf_p = 0,
    parameter int seq_width_p   = 8,
    localparam int addr_width_lp = (num_events_p > 1) ? $clog2(num_events_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [num_events_p-1:0]  event_i,
    input  logic [num_events_p-1:0]  mask_i,
    input  logic                     snap_i,
    input  logic                     clear_on_snap_i,
    input  logic [width_p-1:0]       period_i,
    input  logic                     rd_v_i,
    input  logic [addr_width_lp-1:0] rd_addr_i,
    output logic                     rd_v_o,
    output logic [width_p-1:0]       rd_data_o,
    output logic                     rd_ovf_o,
    output logic                     rd_err_o,
    output logic                     snap_v_o,
    output logic [seq_width_p-1:0]   snap_seq_o,
    output logic                     ovf_any_o,
    output logic                     frozen_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam logic [width_p-1:0]     cnt_max_lp    = '1;
    localparam logic [addr_width_lp:0] num_events_lp = (addr_width_lp+1)'(num_events_p);

    state_e r_state;
    state_e w_state_next;

    logic [width_p-1:0]     r_cnt        [num_events_p];
    logic                   r_ovf        [num_events_p];
    logic [width_p-1:0]     r_shadow     [num_events_p];
    logic                   r_shadow_ovf [num_events_p];
    logic [width_p-1:0]     r_win;
    logic [seq_width_p-1:0] r_seq;
    logic                   r_snap_v;
    logic                   r_rd_v;
    logic                   r_rd_err;
    logic                   r_rd_ovf;
    logic [width_p-1:0]     r_rd_data;

    logic                    w_run;
    logic [num_events_p-1:0] w_inc;
    logic [num_events_p-1:0] w_hit;
    logic [num_events_p-1:0] w_ovf_vec;
    logic                    w_freeze;
    logic                    w_auto;
    logic                    w_snap;
    logic                    w_rd_in_range;

    assign w_run = (r_state == ST_RUN);

    // The comparison tracks period_i live; a window already past period_i just keeps counting and wraps.
    assign w_auto   = w_run & (period_i != '0) & (r_win == (period_i - width_p'(1)));
    assign w_freeze = (stop_on_ovf_p != 0) & w_run & (|w_hit);
    assign w_snap   = snap_i | w_auto | w_freeze;

    assign ovf_any_o = |w_ovf_vec;
    assign frozen_o  = (r_state == ST_FROZEN);

    // Per-channel live counter, sticky flag and shadow copy.
    for (genvar gi = 0; gi < num_events_p; gi++) begin : g_chan
        assign w_inc[gi]     = w_run & en_i & mask_i[gi] & event_i[gi] & ~clear_i;
        assign w_hit[gi]     = w_inc[gi] & (r_cnt[gi] == cnt_max_lp);
        assign w_ovf_vec[gi] = r_ovf[gi];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_cnt[gi] <= '0;
                r_ovf[gi] <= 1'b0;
            end else if (clear_i) begin
                r_cnt[gi] <= '0;
                r_ovf[gi] <= 1'b0;
            end else if (w_snap && clear_on_snap_i) begin
                r_cnt[gi] <= w_inc[gi] ? width_p'(1) : '0;
                r_ovf[gi] <= 1'b0;
            end else if (w_inc[gi]) begin
                if (w_hit[gi]) begin
                    r_cnt[gi] <= (saturate_p != 0) ? cnt_max_lp : '0;
                    r_ovf[gi] <= 1'b1;
                end else begin
                    r_cnt[gi] <= r_cnt[gi] + width_p'(1);
                end
            end
        end

        // A freeze snapshot also records the overflow that caused it, so the host can see why.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_shadow[gi]     <= '0;
                r_shadow_ovf[gi] <= 1'b0;
            end else if (w_snap) begin
                r_shadow[gi]     <= r_cnt[gi];
                r_shadow_ovf[gi] <= r_ovf[gi] | (w_freeze & w_hit[gi]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_win <= '0;
        end else if (clear_i) begin
            r_win <= '0;
        end else if (w_run) begin
            r_win <= w_auto ? '0 : (r_win + width_p'(1));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_seq    <= '0;
            r_snap_v <= 1'b0;
        end else begin
            r_snap_v <= w_snap;
            if (w_snap) begin
                r_seq <= r_seq + seq_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_freeze) begin
                        w_state_next = ST_FROZEN;
                    end else if (!en_i) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_FROZEN: begin
                    w_state_next = ST_FROZEN;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Read port samples the shadow bank as it stood before any snapshot on the same edge.
    assign w_rd_in_range = ({1'b0, rd_addr_i} < num_events_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_v    <= 1'b0;
            r_rd_err  <= 1'b0;
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            r_rd_v   <= rd_v_i;
            r_rd_err <= rd_v_i & ~w_rd_in_range;
            if (rd_v_i && w_rd_in_range) begin
                r_rd_data <= r_shadow[rd_addr_i];
                r_rd_ovf  <= r_shadow_ovf[rd_addr_i];
            end else begin
                r_rd_data <= '0;
                r_rd_ovf  <= 1'b0;
            end
        end
    end

    assign rd_v_o     = r_rd_v;
    assign rd_err_o   = r_rd_err;
    assign rd_data_o  = r_rd_data;
    assign rd_ovf_o   = r_rd_ovf;
    assign snap_v_o   = r_snap_v;
    assign snap_seq_o = r_seq;

endmodule
